// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding and
// the derived digit-count and counter-width helpers.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple of full-adder cells; also exposes the carry
// into the top bit so the caller can form signed overflow.
module digit_adder
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out,
  output logic             c_msb_in
);

  logic carry_s;

  // Ripple the carry through each full-adder cell, LSB first.
  always_comb begin
    carry_s  = c_in;
    c_msb_in = c_in;
    s_d      = {DIGIT{1'b0}};
    for (int i = 0; i < DIGIT; i++) begin
      c_msb_in = carry_s;
      s_d[i]   = a_d[i] ^ b_d[i] ^ carry_s;
      carry_s  = (a_d[i] & b_d[i]) | (carry_s & (a_d[i] ^ b_d[i]));
    end
    c_out = carry_s;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock with a registered carry, valid/ready on both sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_width(NDIG);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             co_r;
  logic             ovf_r;

  logic [DIGIT-1:0] d_sum_s;
  logic             d_cout_s;
  logic             d_cmsb_s;
  logic [WIDTH-1:0] dig_ext_s;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_d      (sa_r[DIGIT-1:0]),
    .b_d      (sb_r[DIGIT-1:0]),
    .c_in     (carry_r),
    .s_d      (d_sum_s),
    .c_out    (d_cout_s),
    .c_msb_in (d_cmsb_s)
  );

  // New digits enter at the top of the result; after NDIG shifts it is aligned.
  assign dig_ext_s = WIDTH'(d_sum_s) << (WIDTH - DIGIT);

  // Control FSM with shift registers, digit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sa_r        <= {WIDTH{1'b0}};
      sb_r        <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      carry_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      co_r        <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            sa_r       <= a;
            sb_r       <= sub ? ~b : b;
            carry_r    <= ci ^ sub;
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= CALC;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        CALC: begin
          sum_r   <= (sum_r >> DIGIT) | dig_ext_s;
          sa_r    <= sa_r >> DIGIT;
          sb_r    <= sb_r >> DIGIT;
          carry_r <= d_cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == CW'(NDIG - 1)) begin
            co_r        <= d_cout_s;
            ovf_r       <= d_cmsb_s ^ d_cout_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign co        = co_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (16/4) plus exhaustive sweeps
// of the 3/1 and 4/4 configurations against a whole-word reference.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // 16-bit, 4-bit digit instance
  logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
  logic [15:0] a, b, sum;
  // 3-bit, 1-bit digit instance
  logic        iv3, ir3, ci3, sub3, ov3, or3, co3, ovf3;
  logic [2:0]  a3, b3, s3;
  // 4-bit, 4-bit digit instance
  logic        iv4, ir4, ci4, sub4, ov4, or4, co4, ovf4;
  logic [3:0]  a4, b4, s4;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .co(co), .ovf(ovf)
  );

  serial_adder #(.WIDTH(3), .DIGIT(1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3),
    .a(a3), .b(b3), .ci(ci3), .sub(sub3), .out_valid(ov3),
    .out_ready(or3), .sum(s3), .co(co3), .ovf(ovf3)
  );

  serial_adder #(.WIDTH(4), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .ci(ci4), .sub(sub4), .out_valid(ov4),
    .out_ready(or4), .sum(s4), .co(co4), .ovf(ovf4)
  );

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                        input logic tci, input logic tsub,
                        output logic [15:0] rs, output logic rco,
                        output logic rovf, output int lat);
    @(negedge clk);
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rco = co; rovf = ovf;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    tests_run++;
    if ({in_ready, out_valid, co, ovf, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%b vld=%b co=%b ovf=%b sum=%h, expected rdy=1 vld=0 co=0 ovf=0 sum=0000",
               in_ready, out_valid, co, ovf, sum);
    end
    tests_run++;
    if ({ir3, ov3, ir4, ov4} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL reset_small: got %b expected 1010", {ir3, ov3, ir4, ov4});
    end
  endtask

  // Directed vectors: {a, b, ci, sub, sum, co, ovf}
  task automatic test_arith;
    logic [15:0] va [8] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h00FF, 16'h0010, 16'h8000};
    logic [15:0] vb [8] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001, 16'h0003, 16'h8000};
    logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [17:0] ve [8] = '{{2'b00, 16'h5555}, {2'b10, 16'h0000}, {2'b01, 16'h8000},
                            {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}, {2'b00, 16'h0101},
                            {2'b10, 16'h000C}, {2'b11, 16'h0000}};
    logic [15:0] rs;
    logic        rco, rovf;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], vc[i], vs[i], rs, rco, rovf, lat);
      tests_run++;
      if ({rco, rovf, rs} !== ve[i]) begin
        tests_failed++;
        $display("FAIL arith[%0d]: got co=%b ovf=%b sum=%h expected co=%b ovf=%b sum=%h",
                 i, rco, rovf, rs, ve[i][17], ve[i][16], ve[i][15:0]);
      end
      tests_run++;
      if (lat !== 4) begin
        tests_failed++;
        $display("FAIL latency[%0d]: got %0d expected 4", i, lat);
      end
    end
  endtask

  task automatic test_handshake;
    int lat;
    @(negedge clk);
    a = 16'h0100; b = 16'h0200; ci = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h1111;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_busy_ready: got %b expected 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL hs_latency: got %0d expected 4", lat);
    end
    repeat (3) begin
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, 16'h0300}) begin
        tests_failed++;
        $display("FAIL hs_hold: got vld=%b rdy=%b sum=%h expected vld=1 rdy=0 sum=0300",
                 out_valid, in_ready, sum);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL hs_release: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_accept_next: got rdy=%b expected 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if ({out_valid, sum} !== {1'b1, 16'hBBBB} || lat !== 4) begin
      tests_failed++;
      $display("FAIL hs_next_result: got vld=%b sum=%h lat=%0d expected vld=1 sum=bbbb lat=4",
               out_valid, sum, lat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [15:0] rs;
    logic        rco, rovf;
    int          lat;
    @(negedge clk);
    a = 16'h00F0; b = 16'h000F; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, co, ovf, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL reset_mid: got rdy=%b vld=%b co=%b ovf=%b sum=%h expected rdy=1 vld=0 co=0 ovf=0 sum=0000",
               in_ready, out_valid, co, ovf, sum);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rco, rovf, lat);
    tests_run++;
    if ({rco, rovf, rs} !== {2'b00, 16'h0002} || lat !== 4) begin
      tests_failed++;
      $display("FAIL after_reset: got co=%b ovf=%b sum=%h lat=%0d expected co=0 ovf=0 sum=0002 lat=4",
               rco, rovf, rs, lat);
    end
  endtask

  task automatic test_exhaustive_w3;
    logic [2:0] ua, bo;
    logic [3:0] tot;
    logic       eovf;
    int         lat;
    for (int ia = 0; ia < 8; ia++)
      for (int ib = 0; ib < 8; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            @(negedge clk);
            a3 = 3'(ia); b3 = 3'(ib); ci3 = 1'(ic); sub3 = 1'(is); iv3 = 1'b1;
            @(posedge clk); #1;
            iv3 = 1'b0;
            lat = 0;
            while (!ov3 && lat < 20) begin
              @(posedge clk); #1;
              lat++;
            end
            ua   = 3'(ia);
            bo   = (is != 0) ? ~3'(ib) : 3'(ib);
            tot  = {1'b0, ua} + {1'b0, bo} + 4'(ic ^ is);
            eovf = (ua[2] == bo[2]) && (tot[2] != ua[2]);
            tests_run++;
            if ({co3, ovf3, s3} !== {tot[3], eovf, tot[2:0]} || lat !== 3) begin
              tests_failed++;
              $display("FAIL w3 a=%0d b=%0d ci=%0d sub=%0d: got co=%b ovf=%b sum=%0d lat=%0d expected co=%b ovf=%b sum=%0d lat=3",
                       ia, ib, ic, is, co3, ovf3, s3, lat, tot[3], eovf, tot[2:0]);
            end
            or3 = 1'b1;
            @(posedge clk); #1;
            or3 = 1'b0;
          end
  endtask

  task automatic test_exhaustive_w4;
    logic [3:0] ua, bo;
    logic [4:0] tot;
    logic       eovf;
    int         lat;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            @(negedge clk);
            a4 = 4'(ia); b4 = 4'(ib); ci4 = 1'(ic); sub4 = 1'(is); iv4 = 1'b1;
            @(posedge clk); #1;
            iv4 = 1'b0;
            lat = 0;
            while (!ov4 && lat < 20) begin
              @(posedge clk); #1;
              lat++;
            end
            ua   = 4'(ia);
            bo   = (is != 0) ? ~4'(ib) : 4'(ib);
            tot  = {1'b0, ua} + {1'b0, bo} + 5'(ic ^ is);
            eovf = (ua[3] == bo[3]) && (tot[3] != ua[3]);
            tests_run++;
            if ({co4, ovf4, s4} !== {tot[4], eovf, tot[3:0]} || lat !== 1) begin
              tests_failed++;
              $display("FAIL w4 a=%0d b=%0d ci=%0d sub=%0d: got co=%b ovf=%b sum=%0d lat=%0d expected co=%b ovf=%b sum=%0d lat=1",
                       ia, ib, ic, is, co4, ovf4, s4, lat, tot[4], eovf, tot[3:0]);
            end
            or4 = 1'b1;
            @(posedge clk); #1;
            or4 = 1'b0;
          end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; ci = 1'b0; sub = 1'b0;
    iv3 = 1'b0; or3 = 1'b0; a3 = 3'd0; b3 = 3'd0; ci3 = 1'b0; sub3 = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; a4 = 4'd0; b4 = 4'd0; ci4 = 1'b0; sub4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    test_reset();
    rst = 1'b0;
    test_arith();
    test_handshake();
    test_reset_mid();
    test_exhaustive_w3();
    test_exhaustive_w4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
